// File: rtl/i_reg_file_sb_pkg.sv
// Shared types and constants for the scoreboarded integer register file.
// No logic; widths here are the default configuration.
// No flow control.
package i_reg_file_sb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int REG_COUNT_DEF  = 32;
  localparam int TAG_WIDTH_DEF  = 4;
  localparam int AW_DEF         = 5;

  typedef logic [DATA_WIDTH_DEF-1:0] data_bus_t;
  typedef logic [TAG_WIDTH_DEF-1:0]  rf_tag_t;

  // A few architectural register names; x0 is the hard-wired zero.
  typedef enum logic [AW_DEF-1:0] {
    REG_ZERO = 5'd0,
    REG_RA   = 5'd1,
    REG_SP   = 5'd2,
    REG_GP   = 5'd3,
    REG_TP   = 5'd4
  } i_register_e;

  localparam logic [AW_DEF-1:0] X0 = REG_ZERO;

  // One writeback port: {valid, addr, tag, data}.
  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    rf_tag_t           tag;
    data_bus_t         data;
  } wr_port_t;

endpackage

// File: rtl/i_reg_file_bypass.sv
// Per-read-port write-to-read bypass: priority match of the read address against accepted writes.
// Combinational, zero latency; the highest-index matching port wins.
// No flow control. Only compiled when MGT_RF_BYPASS_EN is defined.
`ifdef MGT_RF_BYPASS_EN
module i_reg_file_bypass #(
  parameter int DATA_WIDTH  = 32,
  parameter int AW          = 5,
  parameter int WRITE_PORTS = 2
) (
  input  logic [AW-1:0]                     rd_addr_i,
  input  logic [WRITE_PORTS-1:0]            wr_acc_i,
  input  logic [WRITE_PORTS*AW-1:0]         wr_addr_i,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
  output logic                              hit_o,
  output logic [DATA_WIDTH-1:0]             data_o
);

  // Scan ports low to high so a later (higher) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wr_acc_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`endif

// File: rtl/i_reg_file_sb.sv
// Integer register file with per-register busy/tag scoreboard; optional bypass via MGT_RF_BYPASS_EN.
// Reads are combinational (0 cycles); writes and allocates are visible the next cycle.
// No backpressure: stale writebacks (busy with a different tag) are silently dropped.
module i_reg_file_sb
  import i_reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int REG_COUNT   = REG_COUNT_DEF,
  parameter int READ_PORTS  = 6,
  parameter int WRITE_PORTS = 2,
  parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              clk_en_i,
  input  logic                              flush_i,
  input  logic                              alloc_valid_i,
  input  logic [AW-1:0]                     alloc_addr_i,
  input  logic [TAG_WIDTH-1:0]              alloc_tag_i,
  input  logic [WRITE_PORTS-1:0]            we_i,
  input  logic [WRITE_PORTS*AW-1:0]         wr_addr_i,
  input  logic [WRITE_PORTS*TAG_WIDTH-1:0]  wr_tag_i,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
  input  logic [READ_PORTS*AW-1:0]          rd_addr_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data_o,
  output logic [READ_PORTS-1:0]             rd_busy_o,
  output logic [READ_PORTS*TAG_WIDTH-1:0]   rd_tag_o
);

  logic [DATA_WIDTH-1:0] r_data [REG_COUNT];
  logic [REG_COUNT-1:0]  r_busy;
  logic [TAG_WIDTH-1:0]  r_tag  [REG_COUNT];

  logic [AW-1:0]          w_wr_addr [WRITE_PORTS];
  logic [TAG_WIDTH-1:0]   w_wr_tag  [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  w_wr_data [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] w_wr_acc;
  logic                   w_alloc;

  // Acceptance is computed once from pre-edge state and feeds both storage and bypass.
  for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_wr
    assign w_wr_addr[p] = wr_addr_i[p*AW +: AW];
    assign w_wr_tag[p]  = wr_tag_i[p*TAG_WIDTH +: TAG_WIDTH];
    assign w_wr_data[p] = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
    assign w_wr_acc[p]  = we_i[p] && (w_wr_addr[p] != AW'(X0)) &&
                          (!r_busy[w_wr_addr[p]] || (r_tag[w_wr_addr[p]] == w_wr_tag[p]));
  end

  assign w_alloc = alloc_valid_i && (alloc_addr_i != AW'(X0));

  // Data storage: later ports are applied last so the highest index wins a collision.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_COUNT; i++) r_data[i] <= '0;
    end else if (clk_en_i) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (w_wr_acc[p]) r_data[w_wr_addr[p]] <= w_wr_data[p];
      end
    end
  end

  // Scoreboard: flush clears everything and discards allocates; allocate overrides a same-cycle writeback.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_tag[i] <= '0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        r_busy <= '0;
        for (int i = 0; i < REG_COUNT; i++) r_tag[i] <= '0;
      end else begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (w_wr_acc[p]) r_busy[w_wr_addr[p]] <= 1'b0;
        end
        if (w_alloc) begin
          r_busy[alloc_addr_i] <= 1'b1;
          r_tag[alloc_addr_i]  <= alloc_tag_i;
        end
      end
    end
  end

`ifdef MGT_RF_BYPASS_EN
  logic [READ_PORTS-1:0] w_byp_hit;
  logic [DATA_WIDTH-1:0] w_byp_data [READ_PORTS];

  for (genvar r = 0; r < READ_PORTS; r++) begin : g_byp
    i_reg_file_bypass #(
      .DATA_WIDTH  (DATA_WIDTH),
      .AW          (AW),
      .WRITE_PORTS (WRITE_PORTS)
    ) u_bypass (
      .rd_addr_i (rd_addr_i[r*AW +: AW]),
      .wr_acc_i  (w_wr_acc),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .hit_o     (w_byp_hit[r]),
      .data_o    (w_byp_data[r])
    );
  end
`endif

  // Read ports: x0 reads as zero/idle; otherwise stored state, optionally overridden by a bypass hit.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_tag_o  = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      if (rd_addr_i[r*AW +: AW] != AW'(X0)) begin
        rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = r_data[rd_addr_i[r*AW +: AW]];
        rd_busy_o[r]                          = r_busy[rd_addr_i[r*AW +: AW]];
        rd_tag_o[r*TAG_WIDTH +: TAG_WIDTH]    = r_tag[rd_addr_i[r*AW +: AW]];
`ifdef MGT_RF_BYPASS_EN
        if (w_byp_hit[r]) begin
          rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = w_byp_data[r];
          rd_busy_o[r]                          = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_i_reg_file_sb.sv
// Bench for i_reg_file_sb: directed scenarios plus random traffic against an array-based model.
// Expected read results are queued when stimulus is applied; a negedge monitor pops and compares.
module tb_i_reg_file_sb;
  import i_reg_file_sb_pkg::*;

  localparam int NR = 6;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TW = 4;

  logic              clk_i;
  logic              rst_n_i;
  logic              clk_en_i;
  logic              flush_i;
  logic              alloc_valid_i;
  logic [AW-1:0]     alloc_addr_i;
  logic [TW-1:0]     alloc_tag_i;
  logic [NW-1:0]     we_i;
  logic [NW*AW-1:0]  wr_addr_i;
  logic [NW*TW-1:0]  wr_tag_i;
  logic [NW*DW-1:0]  wr_data_i;
  logic [NR*AW-1:0]  rd_addr_i;
  logic [NR*DW-1:0]  rd_data_o;
  logic [NR-1:0]     rd_busy_o;
  logic [NR*TW-1:0]  rd_tag_o;

  i_reg_file_sb dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .clk_en_i      (clk_en_i),
    .flush_i       (flush_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .alloc_tag_i   (alloc_tag_i),
    .we_i          (we_i),
    .wr_addr_i     (wr_addr_i),
    .wr_tag_i      (wr_tag_i),
    .wr_data_i     (wr_data_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data_o     (rd_data_o),
    .rd_busy_o     (rd_busy_o),
    .rd_tag_o      (rd_tag_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: architectural state as plain arrays.
  logic [DW-1:0] m_data [32];
  logic          m_busy [32];
  logic [TW-1:0] m_tag  [32];

  // Stimulus for the current cycle.
  wr_port_t      wp [NW];
  logic [AW-1:0] ra [NR];
  logic          s_en, s_fl, s_av;
  logic [AW-1:0] s_aa;
  rf_tag_t       s_at;

  // Scoreboard queues.
  int            q_port [$];
  logic [DW-1:0] q_data [$];
  logic          q_busy [$];
  logic [TW-1:0] q_tag  [$];
  string         q_name [$];

  int checks = 0;
  int errors = 0;

  function automatic logic accepted(int p);
    return wp[p].valid && (wp[p].addr != 0) &&
           (!m_busy[wp[p].addr] || (m_tag[wp[p].addr] == wp[p].tag));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic model_apply();
    logic acc [NW];
    for (int p = 0; p < NW; p++) acc[p] = accepted(p);
    for (int p = 0; p < NW; p++) begin
      if (acc[p]) begin
        m_data[wp[p].addr] = wp[p].data;
        m_busy[wp[p].addr] = 1'b0;
      end
    end
    if (s_fl) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else if (s_av && s_aa != 0) begin
      m_busy[s_aa] = 1'b1;
      m_tag[s_aa]  = s_at;
    end
  endtask

  task automatic push(int r, logic [DW-1:0] d, logic b, logic [TW-1:0] t, string nm);
    q_port.push_back(r);
    q_data.push_back(d);
    q_busy.push_back(b);
    q_tag.push_back(t);
    q_name.push_back(nm);
  endtask

  task automatic set_idle();
    s_en = 1'b1; s_fl = 1'b0; s_av = 1'b0; s_aa = '0; s_at = '0;
    for (int p = 0; p < NW; p++) wp[p] = '0;
    for (int r = 0; r < NR; r++) ra[r] = AW'(r + 1);
  endtask

  task automatic wr(int p, logic [AW-1:0] a, logic [TW-1:0] t, logic [DW-1:0] d);
    wp[p] = '{1'b1, a, t, d};
  endtask

  task automatic pack();
    clk_en_i      = s_en;
    flush_i       = s_fl;
    alloc_valid_i = s_av;
    alloc_addr_i  = s_aa;
    alloc_tag_i   = s_at;
    for (int p = 0; p < NW; p++) begin
      we_i[p]              = wp[p].valid;
      wr_addr_i[p*AW +: AW] = wp[p].addr;
      wr_tag_i[p*TW +: TW]  = wp[p].tag;
      wr_data_i[p*DW +: DW] = wp[p].data;
    end
    for (int r = 0; r < NR; r++) rd_addr_i[r*AW +: AW] = ra[r];
  endtask

  // Expected read response from the model, including same-cycle bypass when enabled.
  task automatic push_model(string nm);
    logic [DW-1:0] d;
    logic          b;
    logic [TW-1:0] t;
    for (int r = 0; r < NR; r++) begin
      if (ra[r] == 0) begin
        d = '0; b = 1'b0; t = '0;
      end else begin
        d = m_data[ra[r]]; b = m_busy[ra[r]]; t = m_tag[ra[r]];
`ifdef MGT_RF_BYPASS_EN
        for (int p = 0; p < NW; p++) begin
          if (accepted(p) && wp[p].addr == ra[r]) begin
            d = wp[p].data;
            b = 1'b0;
          end
        end
`endif
      end
      push(r, d, b, t, nm);
    end
  endtask

  task automatic go(string nm);
    pack();
    push_model(nm);
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (s_en) model_apply();
    #1;
  endtask

  // Assert reset asynchronously mid-cycle; outputs must be zero before any clock edge.
  task automatic reset_mid();
    set_idle();
    pack();
    #1;
    rst_n_i = 1'b0;
    model_reset();
    push_model("reset");
    #1;
    checks++;
    if (rd_data_o !== '0 || rd_busy_o !== '0 || rd_tag_o !== '0) begin
        errors++;
        $display("FAIL reset_immediate: data=%h busy=%b tag=%h", rd_data_o, rd_busy_o, rd_tag_o);
    end
    @(negedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: reads are valid every cycle; compare away from the rising edge.
  always @(negedge clk_i) begin : mon
    int            r;
    logic [DW-1:0] ed, ad;
    logic          eb, ab;
    logic [TW-1:0] et, at;
    string         nm;
    while (q_port.size() > 0) begin
      r  = q_port.pop_front();
      ed = q_data.pop_front();
      eb = q_busy.pop_front();
      et = q_tag.pop_front();
      nm = q_name.pop_front();
      ad = rd_data_o[r*DW +: DW];
      ab = rd_busy_o[r];
      at = rd_tag_o[r*TW +: TW];
      checks++;
      if (ad !== ed || ab !== eb || at !== et) begin
        errors++;
        $display("FAIL %s port%0d addr%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h",
                 nm, r, rd_addr_i[r*AW +: AW], ad, ab, at, ed, eb, et);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic [AW-1:0] a;
    logic [TW-1:0] t;
    rst_n_i = 1'b1;
    set_idle();
    pack();
    reset_mid();

    // Fill a few registers, then reset asynchronously mid-cycle.
    for (int c = 0; c < 3; c++) begin
      set_idle();
      wr(0, AW'(2*c + 1), '0, $urandom);
      wr(1, AW'(2*c + 2), '0, $urandom);
      go("prefill"); tick();
    end
    reset_mid();

    // Allocate then writeback.
    set_idle(); s_av = 1'b1; s_aa = 5'd5; s_at = 4'd3; go("alloc"); tick();
    set_idle(); ra[0] = 5'd5; go("alloc_rd"); push(0, 32'h0, 1'b1, 4'd3, "alloc_busy");
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b1 || rd_tag_o[TW-1:0] !== 4'd3) begin
        errors++;
        $display("FAIL alloc_direct: busy=%b tag=%h", rd_busy_o[0], rd_tag_o[TW-1:0]);
    end
    tick();
    set_idle(); ra[0] = 5'd1; wr(0, 5'd5, 4'd3, 32'hDEADBEEF); go("wb"); tick();
    set_idle(); ra[0] = 5'd5; go("wb_rd"); push(0, 32'hDEADBEEF, 1'b0, 4'd3, "writeback");
    #1;
    checks++;
    if (rd_data_o[DW-1:0] !== 32'hDEADBEEF || rd_busy_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL wb_direct: data=%h busy=%b", rd_data_o[DW-1:0], rd_busy_o[0]);
    end
    tick();

    // Stale write dropped.
    set_idle(); s_av = 1'b1; s_aa = 5'd7; s_at = 4'd2; go("alloc7"); tick();
    set_idle(); ra[0] = 5'd7; wr(0, 5'd7, 4'd1, 32'h11); go("stale");
    push(0, 32'h0, 1'b1, 4'd2, "stale_same_cycle"); tick();
    set_idle(); ra[0] = 5'd7; go("stale_rd"); push(0, 32'h0, 1'b1, 4'd2, "stale_drop"); tick();

    // Two ports write the same register: higher port wins.
    set_idle(); ra[0] = 5'd1; wr(0, 5'd9, '0, 32'hA); wr(1, 5'd9, '0, 32'hB); go("coll"); tick();
    set_idle(); ra[0] = 5'd9; go("coll_rd"); push(0, 32'hB, 1'b0, 4'd0, "collision");
    #1;
    checks++;
    if (rd_data_o[DW-1:0] !== 32'hB) begin
        errors++;
        $display("FAIL coll_direct: data=%h", rd_data_o[DW-1:0]);
    end
    tick();

    // Same-cycle allocate and writeback: data written, scoreboard takes the allocate.
    set_idle(); s_av = 1'b1; s_aa = 5'd4; s_at = 4'd6; go("alloc4"); tick();
    set_idle(); ra[3] = 5'd1; wr(0, 5'd4, 4'd6, 32'h55); s_av = 1'b1; s_aa = 5'd4; s_at = 4'd9;
    go("alloc_wb"); tick();
    set_idle(); ra[0] = 5'd4; go("alloc_wb_rd"); push(0, 32'h55, 1'b1, 4'd9, "alloc_wins"); tick();

    // Flush with a same-cycle allocate.
    set_idle(); s_fl = 1'b1; s_av = 1'b1; s_aa = 5'd8; s_at = 4'd5; go("flush"); tick();
    set_idle(); ra[0] = 5'd8; ra[1] = 5'd4; ra[2] = 5'd7; go("flush_rd");
    push(0, 32'h0, 1'b0, 4'd0, "flush_alloc");
    push(1, 32'h55, 1'b0, 4'd0, "flush_x4");
    push(2, 32'h0, 1'b0, 4'd0, "flush_x7");
    tick();

    // Register 0 ignores writes and allocates.
    set_idle(); wr(1, 5'd0, '0, 32'hFF); s_av = 1'b1; s_aa = 5'd0; s_at = 4'd7; go("x0_wr"); tick();
    set_idle(); ra[0] = 5'd0; go("x0_rd"); push(0, 32'h0, 1'b0, 4'd0, "x0_zero"); tick();

    // clk_en low holds state.
    set_idle(); ra[2] = 5'd1; wr(0, 5'd3, '0, 32'h33); go("x3_wr"); tick();
    set_idle(); ra[2] = 5'd1; s_en = 1'b0; wr(0, 5'd3, '0, 32'h77); go("x3_hold"); tick();
    set_idle(); ra[0] = 5'd3; go("x3_rd"); push(0, 32'h33, 1'b0, 4'd0, "clk_en_hold"); tick();

    // Same-cycle read of a written register.
    set_idle(); ra[0] = 5'd12; wr(0, 5'd12, '0, 32'h1234); go("byp");
`ifdef MGT_RF_BYPASS_EN
    push(0, 32'h1234, 1'b0, 4'd0, "bypass_hit");
`else
    push(0, 32'h0, 1'b0, 4'd0, "no_bypass_old");
`endif
    tick();
    set_idle(); ra[0] = 5'd12; go("byp_next"); push(0, 32'h1234, 1'b0, 4'd0, "write_next"); tick();

    // Random traffic on a narrow address range to force collisions and tag matches.
    for (int c = 0; c < 300; c++) begin
      set_idle();
      s_en = ($urandom_range(9) != 0);
      s_fl = ($urandom_range(19) == 0);
      s_av = ($urandom_range(1) == 1);
      s_aa = AW'($urandom_range(15));
      s_at = TW'($urandom_range(15));
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(9) < 6) begin
          a = AW'($urandom_range(15));
          t = ($urandom_range(1) == 1) ? m_tag[a] : TW'($urandom_range(15));
          wr(p, a, t, $urandom);
        end
      end
      for (int r = 0; r < NR; r++) ra[r] = AW'($urandom_range(15));
      go("random");
      tick();
      if (c == 150) reset_mid();
    end

    set_idle(); go("final"); tick();
    @(negedge clk_i);
    #1;
    if (errors != 0) $display("FAIL %0d mismatches", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_reg_file_sb.md
Name: i_reg_file_sb

Overview:
- Parametrised integer register file with a per-register scoreboard (busy bit plus producer tag) and same-cycle write-to-read bypass.
- Serves out-of-order issue: the issue stage allocates a destination register and tag, and writeback clears the entry only when its tag matches.
- Operand reads return data, busy and tag, so the dispatcher can capture a value or wait on a tag.
- Register 0 is hard-wired to zero and is never busy.

Parameters:
- DATA_WIDTH, 32, register width.
- REG_COUNT, 32, number of architectural registers; must be a power of 2; AW = log2(REG_COUNT).
- READ_PORTS, 6, number of combinational read ports.
- WRITE_PORTS, 2, number of writeback ports; a higher index has priority on an address collision.
- TAG_WIDTH, 4, producer tag width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- clk_en_i  in  1  state-update enable; when low, all state holds.
- flush_i  in  1  pipeline flush: clears the whole scoreboard.
- alloc_valid_i  in  1  allocate a destination register.
- alloc_addr_i  in  AW  register to mark busy.
- alloc_tag_i  in  TAG_WIDTH  producer tag stored with the busy bit.
- we_i  in  WRITE_PORTS  per-port write valid.
- wr_addr_i  in  WRITE_PORTS x AW  write addresses.
- wr_tag_i  in  WRITE_PORTS x TAG_WIDTH  producer tag of each write.
- wr_data_i  in  WRITE_PORTS x DATA_WIDTH  write data.
- rd_addr_i  in  READ_PORTS x AW  read addresses.
- rd_data_o  out  READ_PORTS x DATA_WIDTH  read data.
- rd_busy_o  out  READ_PORTS  register still awaiting its producer.
- rd_tag_o  out  READ_PORTS x TAG_WIDTH  stored producer tag.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset, at any time including mid-operation: all data cleared to 0, busy to 0, tags to 0. Outputs are therefore rd_data_o=0, rd_busy_o=0, rd_tag_o=0.
- State update: occurs on the clock edge only when clk_en_i=1. Reset overrides clk_en_i.
- Write acceptance, port p, per cycle: we_i[p] & wr_addr_i[p]!=0 & (!busy[a] | tag[a]==wr_tag_i[p]).
  - Evaluated against the pre-edge state.
  - A stale write (busy with a tag mismatch) is silently dropped.
- Accepted write: data[a] <= wr_data_i[p]; busy[a] <= 0.
- Write collision: two accepted writes to the same address take the highest port index.
- Allocate: alloc_valid_i & alloc_addr_i!=0 sets busy[a] <= 1 and tag[a] <= alloc_tag_i on the next edge.
  - Allocate to register 0 is ignored.
- Allocate with a write to the same register in the same cycle: data is written if accepted, but busy=1 and tag=alloc_tag_i (the allocate wins the scoreboard).
- Flush: every busy bit <= 0 and every tag <= 0.
  - An allocate in the same cycle is discarded.
  - Writes in the same cycle are still accepted per the pre-edge state and update data.
- Reads: combinational, zero latency.
  - Reading address 0 returns data 0, busy 0, tag 0.
  - Otherwise a read returns the stored data, busy and tag, subject to the bypass below.
  - An allocate is never bypassed; its busy and tag are visible from the next cycle.
- Latency: a write becomes visible next cycle without bypass, or the same cycle with bypass.

Optional Feature:
- Macro: MGT_RF_BYPASS_EN.
- Defined: a read that matches an accepted write in the same cycle returns that write's data with busy=0 (tag output unchanged). The highest-index matching port wins. The bypass applies regardless of clk_en_i.
- Undefined: reads return pre-edge stored state only. There are no write-to-read paths, which gives a shorter critical path.

Decomposition:
- Shared package:
  - data_bus_t sized by DATA_WIDTH;
  - the i_register_e enumeration;
  - a rf_tag_t typedef;
  - an X0 constant;
  - a write-port struct {valid, addr, tag, data}.
- Sub-module i_reg_file_bypass, one instance per read port: a priority match of rd_addr against the accepted writes, producing {hit, data}. It is instantiated only under MGT_RF_BYPASS_EN.
- The acceptance logic is shared between the storage and the bypass, so there is a single source of truth.

Test Plan:
1. Reset: reset asserted asynchronously mid-cycle after writes -> all reads return data 0, busy 0, tag 0 immediately, without waiting for a clock edge.
2. Alloc then writeback:
   - alloc x5 tag 3 -> next cycle rd_busy=1, rd_tag=3.
   - write x5 tag 3 data 0xDEADBEEF -> next cycle data 0xDEADBEEF, busy 0.
3. Stale and collision writes:
   - x7 busy with tag 2; write x7 tag 1 data 0x11 -> dropped, busy stays 1, data unchanged.
   - Ports 0 and 1 both write x9 (not busy) with 0xA and 0xB -> reads 0xB.
4. Same-cycle alloc and write, then flush:
   - x4 busy tag 6; write x4 tag 6 data 0x55 together with alloc x4 tag 9 -> data 0x55, busy 1, tag 9.
   - flush_i together with alloc x8 -> all busy 0, x8 not busy.
5. Register 0 and clk_en:
   - write x0 data 0xFF plus alloc x0 -> read x0 returns 0, busy 0.
   - clk_en_i=0 with a valid write to x3 -> x3 unchanged.
6. Bypass:
   - With MGT_RF_BYPASS_EN: read x12 in the same cycle as an accepted write of 0x1234 -> rd_data=0x1234, busy 0.
   - Without it -> the old value is returned, and 0x1234 appears next cycle.
